fetch_decode_queue: RTL and testbench

Parametrised fetch-to-decode boundary. It replaces the single F/D pipeline register with a DEPTH-entry circular instruction queue feeding a decode-stage output register. Fetch can run ahead of a stalled decode stage until the queue fills. Flush clears all queued and in-flight entries and presents a NOP with valid low.

---
 rtl/fetch_decode_queue.sv | 131 +++++++++++++
 tb/tb_fetch_decode_queue.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_decode_queue
// Brief    : DEPTH-entry circular instruction queue between fetch and a
//            registered decode stage. Optional macro FDQ_BYPASS_EN enables a
//            fetch-to-D bypass when the queue is empty and decode is free.
// Revision : 1.0  initial release
// ============================================================================
module fetch_decode_queue #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       StallD,
    input  logic                       FlushD,
    input  logic                       ValidF,
    input  logic [DATA_WIDTH-1:0]      pcF,
    input  logic [DATA_WIDTH-1:0]      instr,
    input  logic [DATA_WIDTH-1:0]      PCPlus4F,
    output logic                       FullF,
    output logic [$clog2(DEPTH):0]     CountQ,
    output logic [DATA_WIDTH-1:0]      instrD,
    output logic [DATA_WIDTH-1:0]      pcD,
    output logic [DATA_WIDTH-1:0]      PCPlus4D,
    output logic                       ValidD
);

    localparam int                 c_PTR_W     = $clog2(DEPTH);
    localparam int                 c_CNT_W     = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);

    logic [DATA_WIDTH-1:0] r_mem_instr [DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_pc    [DEPTH];
    logic [DATA_WIDTH-1:0] r_mem_pc4   [DEPTH];

    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_CNT_W-1:0]    r_count;

    logic [DATA_WIDTH-1:0] r_instr_d;
    logic [DATA_WIDTH-1:0] r_pc_d;
    logic [DATA_WIDTH-1:0] r_pc4_d;
    logic                  r_valid_d;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_bypass;
    logic [c_CNT_W-1:0]    w_count_next;

    assign w_full  = (r_count == c_DEPTH_CNT);
    assign w_empty = (r_count == '0);
    assign w_pop   = !StallD && !w_empty;

`ifdef FDQ_BYPASS_EN
    assign w_bypass = !StallD && w_empty && ValidF;
`else
    assign w_bypass = 1'b0;
`endif

    // A pop freeing a slot while full does not admit a push: fetch retries.
    assign w_push = ValidF && !w_full && !w_bypass;

    assign w_count_next = r_count
                        + {{(c_CNT_W-1){1'b0}}, w_push}
                        - {{(c_CNT_W-1){1'b0}}, w_pop};

    always_ff @(posedge clk) begin
        if (!rst && !FlushD && w_push) begin
            r_mem_instr[r_wr_ptr] <= instr;
            r_mem_pc[r_wr_ptr]    <= pcF;
            r_mem_pc4[r_wr_ptr]   <= PCPlus4F;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_instr_d <= NOP_INSTR;
            r_pc_d    <= '0;
            r_pc4_d   <= '0;
            r_valid_d <= 1'b0;
        end else if (FlushD) begin
            // PC fields deliberately hold; only the instruction becomes a NOP.
            r_count   <= '0;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_instr_d <= NOP_INSTR;
            r_valid_d <= 1'b0;
        end else begin
            r_count <= w_count_next;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (!StallD) begin
                if (w_pop) begin
                    r_instr_d <= r_mem_instr[r_rd_ptr];
                    r_pc_d    <= r_mem_pc[r_rd_ptr];
                    r_pc4_d   <= r_mem_pc4[r_rd_ptr];
                    r_valid_d <= 1'b1;
                end else if (w_bypass) begin
                    r_instr_d <= instr;
                    r_pc_d    <= pcF;
                    r_pc4_d   <= PCPlus4F;
                    r_valid_d <= 1'b1;
                end else begin
                    r_instr_d <= NOP_INSTR;
                    r_valid_d <= 1'b0;
                end
            end
        end
    end

    assign FullF    = w_full;
    assign CountQ   = r_count;
    assign instrD   = r_instr_d;
    assign pcD      = r_pc_d;
    assign PCPlus4D = r_pc4_d;
    assign ValidD   = r_valid_d;

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_decode_queue
// Brief    : Self-checking bench for fetch_decode_queue (vector table, directed
//            corner sequences and random traffic against a queue-based model).
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_decode_queue;

    localparam int          c_DW    = 32;
    localparam int          c_DEPTH = 4;
    localparam logic [31:0] c_NOP   = 32'h00000013;
    localparam logic [31:0] c_KEY   = 32'hDEAD0000;
`ifdef FDQ_BYPASS_EN
    localparam bit          c_BYP   = 1'b1;
`else
    localparam bit          c_BYP   = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            StallD = 1'b0;
    logic            FlushD = 1'b0;
    logic            ValidF = 1'b0;
    logic [c_DW-1:0] pcF = '0;
    logic [c_DW-1:0] instr = '0;
    logic [c_DW-1:0] PCPlus4F = '0;
    logic            FullF;
    logic [2:0]      CountQ;
    logic [c_DW-1:0] instrD;
    logic [c_DW-1:0] pcD;
    logic [c_DW-1:0] PCPlus4D;
    logic            ValidD;

    fetch_decode_queue #(
        .DATA_WIDTH (c_DW),
        .DEPTH      (c_DEPTH),
        .NOP_INSTR  (c_NOP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .StallD   (StallD),
        .FlushD   (FlushD),
        .ValidF   (ValidF),
        .pcF      (pcF),
        .instr    (instr),
        .PCPlus4F (PCPlus4F),
        .FullF    (FullF),
        .CountQ   (CountQ),
        .instrD   (instrD),
        .pcD      (pcD),
        .PCPlus4D (PCPlus4D),
        .ValidD   (ValidD)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] pc4;
    } entry_t;

    // Reference model: plain queue plus the decode register contents
    entry_t      m_q[$];
    logic [31:0] m_instr_d;
    logic [31:0] m_pc_d;
    logic [31:0] m_pc4_d;
    logic        m_valid_d;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit st, input bit fl, input bit v, input entry_t e);
        int  sz;
        bit  full, take_head, take_fetch, store;
        entry_t h;
        sz = m_q.size();
        if (r) begin
            m_q.delete();
            m_instr_d = c_NOP; m_pc_d = '0; m_pc4_d = '0; m_valid_d = 1'b0;
        end else if (fl) begin
            m_q.delete();
            m_instr_d = c_NOP; m_valid_d = 1'b0;
        end else begin
            full       = (sz == c_DEPTH);
            take_head  = !st && sz > 0;
            take_fetch = c_BYP && !st && sz == 0 && v;
            store      = v && !full && !take_fetch;
            if (!st) begin
                if (take_head) begin
                    h = m_q.pop_front();
                    m_instr_d = h.ins; m_pc_d = h.pc; m_pc4_d = h.pc4; m_valid_d = 1'b1;
                end else if (take_fetch) begin
                    m_instr_d = e.ins; m_pc_d = e.pc; m_pc4_d = e.pc4; m_valid_d = 1'b1;
                end else begin
                    m_instr_d = c_NOP; m_valid_d = 1'b0;
                end
            end
            if (store) m_q.push_back(e);
        end
    endtask

    task automatic step(input bit r, input bit st, input bit fl, input bit v,
                        input logic [31:0] pc, input logic [31:0] ins, input bit chk);
        entry_t e;
        e.ins = ins; e.pc = pc; e.pc4 = pc + 32'd4;
        rst = r; StallD = st; FlushD = fl; ValidF = v;
        pcF = e.pc; instr = e.ins; PCPlus4F = e.pc4;
        @(posedge clk);
        model_step(r, st, fl, v, e);
        #1;
        if (chk) begin
            check("CountQ", {29'd0, CountQ}, m_q.size());
            check("FullF", {31'd0, FullF}, {31'd0, m_q.size() == c_DEPTH});
            check("ValidD", {31'd0, ValidD}, {31'd0, m_valid_d});
            check("instrD", instrD, m_instr_d);
            check("pcD", pcD, m_pc_d);
            check("PCPlus4D", PCPlus4D, m_pc4_d);
        end
    endtask

    typedef struct {
        bit          r, st, fl, v;
        logic [31:0] pc;
        int          cnt;
        bit          full;
        bit          vd;
        logic [31:0] pcd;
    } vec_t;

    vec_t vecs[17];

    initial begin
        int          c_seen300;
        logic [31:0] exp_pc;

        // rst st fl v pc | count full validD pcD
        vecs[0]  = '{1,0,0,0,32'h000, 0,0,0,32'h000};
        vecs[1]  = '{1,0,0,0,32'h000, 0,0,0,32'h000};
        vecs[2]  = '{0,0,0,0,32'h000, 0,0,0,32'h000};
        vecs[3]  = '{0,1,0,1,32'h200, 1,0,0,32'h000};
        vecs[4]  = '{0,1,0,1,32'h204, 2,0,0,32'h000};
        vecs[5]  = '{0,1,0,1,32'h208, 3,0,0,32'h000};
        vecs[6]  = '{0,1,0,1,32'h20C, 4,1,0,32'h000};
        vecs[7]  = '{0,1,0,1,32'h210, 4,1,0,32'h000};
        vecs[8]  = '{0,0,0,0,32'h000, 3,0,1,32'h200};
        vecs[9]  = '{0,0,0,0,32'h000, 2,0,1,32'h204};
        vecs[10] = '{0,0,0,0,32'h000, 1,0,1,32'h208};
        vecs[11] = '{0,0,0,0,32'h000, 0,0,1,32'h20C};
        vecs[12] = '{0,0,0,0,32'h000, 0,0,0,32'h20C};
        vecs[13] = '{0,1,0,1,32'h400, 1,0,0,32'h20C};
        vecs[14] = '{0,1,0,1,32'h404, 2,0,0,32'h20C};
        vecs[15] = '{0,1,1,1,32'h408, 0,0,0,32'h20C};
        vecs[16] = '{0,0,0,0,32'h000, 0,0,0,32'h20C};

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].r, vecs[i].st, vecs[i].fl, vecs[i].v, vecs[i].pc,
                 vecs[i].pc ^ c_KEY, 1'b0);
            check($sformatf("vec%0d CountQ", i), {29'd0, CountQ}, vecs[i].cnt);
            check($sformatf("vec%0d FullF", i), {31'd0, FullF}, {31'd0, vecs[i].full});
            check($sformatf("vec%0d ValidD", i), {31'd0, ValidD}, {31'd0, vecs[i].vd});
            check($sformatf("vec%0d pcD", i), pcD, vecs[i].pcd);
            check($sformatf("vec%0d PCPlus4D", i), PCPlus4D,
                  (vecs[i].pcd == 0) ? 32'd0 : vecs[i].pcd + 32'd4);
            check($sformatf("vec%0d instrD", i), instrD,
                  vecs[i].vd ? (vecs[i].pcd ^ c_KEY) : c_NOP);
        end

        // Streaming with no stall, then drain
        step(1,0,0,0,0,0,1);
        for (int i = 0; i < 3; i++) step(0,0,0,1, 32'h100 + 32'(4*i), 32'h1000 + 32'(i), 1);
        step(0,0,0,0,0,0,1);
        step(0,0,0,0,0,0,1);
        check("stream last pcD", pcD, 32'h108);

        // Flush mid-stream with occupancy 3 and a fetch in the same cycle
        step(1,0,0,0,0,0,1);
        for (int i = 0; i < 3; i++) step(0,1,0,1, 32'h500 + 32'(4*i), 32'h55, 1);
        step(0,0,1,1, 32'h300, 32'h33, 1);
        check("flush CountQ", {29'd0, CountQ}, 0);
        c_seen300 = 0;
        for (int i = 0; i < 4; i++) begin
            step(0,0,0,0,0,0,1);
            if (pcD == 32'h300) c_seen300++;
        end
        check("flushed pc seen", c_seen300, 0);

        // Pointer wrap at steady occupancy 2
        step(1,0,0,0,0,0,1);
        step(0,1,0,1, 32'h600, 32'h60, 1);
        step(0,1,0,1, 32'h604, 32'h61, 1);
        exp_pc = 32'h600;
        for (int i = 0; i < 10; i++) begin
            step(0,0,0,1, 32'h608 + 32'(4*i), 32'h62 + 32'(i), 1);
            check("wrap CountQ", {29'd0, CountQ}, 2);
            check("wrap order", pcD, exp_pc);
            exp_pc = exp_pc + 32'd4;
        end

        // Random traffic
        step(1,0,0,0,0,0,1);
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 64) == 0, ($urandom % 3) == 0, ($urandom % 16) == 0,
                 ($urandom % 3) != 0, $urandom, $urandom, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
